flow_ctrl_sequencer: RTL and testbench
======================================

Name: flow_ctrl_sequencer

Overview:
- Multi-cycle sequencer for control transfers that touch the stack: CALL, RET, RTI and hardware interrupt entry.
- Sits beside the combinational branch resolver at EX/MEM. Plain JZ/JN/JC/JV/LOOP/JMP stay single-cycle in the resolver.
- For stack transfers it stalls the pipeline, pushes/pops PC and flags through the shared data-memory port, updates SP (R3), then loads PC and flushes the younger stages.

Parameters:
- INT_VEC_ADDR, 8'h01, data-memory address that holds the ISR start address.
- SP_RESET, 8'hFF, documentation only; SP reset is owned by the register file.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ex_mem_is_call  in  1  CALL at EX/MEM, single-cycle pulse
- ex_mem_is_ret  in  1  RET at EX/MEM, single-cycle pulse
- ex_mem_is_rti  in  1  RTI at EX/MEM, single-cycle pulse
- call_target  in  8  R[rb] for CALL
- ret_addr_in  in  8  PC+1 of the CALL
- int_pc_in  in  8  PC of the oldest unretired instruction, used for interrupt return
- intr  in  1  external interrupt, level-sensitive
- flags_in  in  4  {V,C,N,Z} current flags
- sp_in  in  8  current R3
- mem_grant  in  1  data-memory arbiter grant
- mem_rdata  in  8  read data, valid the cycle after a granted read
- mem_req  out  1  memory request
- mem_we  out  1  1=write, 0=read
- mem_addr  out  8  memory address
- mem_wdata  out  8  write data
- sp_we  out  1  SP write strobe
- sp_wdata  out  8  new SP
- flags_we  out  1  flags restore strobe
- flags_wdata  out  4  restored flags
- pc_load  out  1  PC load strobe, 1 cycle
- pc_load_value  out  8  new PC
- stall  out  1  freeze IF/ID/EX
- flush  out  1  squash IF/ID/ID/EX, 1 cycle, coincident with pc_load
- int_active  out  1  ISR in progress; blocks nested interrupts

Behaviour:
- Reset: FSM=IDLE; all outputs 0; int_active=0; internal PC/flags latches cleared. A reset mid-sequence abandons the transfer; a half-done push is not undone.
- Stack convention:
  - push: M[SP]<=X, then SP<=SP-1
  - pop: SP<=SP+1, then X<=M[SP+1]
- Memory handshake:
  - mem_req/we/addr/wdata are held stable until a cycle with mem_grant=1.
  - A write completes in its grant cycle.
  - For a read, mem_rdata is captured the cycle after grant; mem_req is low in that capture cycle.
- FSM states: IDLE, PUSH_PC, PUSH_FL, RD_VEC, WAIT_RD, POP_FL, POP_PC, DONE.
- IDLE: stall=0. Priority (highest first): rti > ret > call > (intr & ~int_active). Instructions always win over intr.
  - call: latch ret_addr_in and call_target; go to PUSH_PC.
  - ret: go to POP_PC.
  - rti: go to POP_FL.
  - intr: latch int_pc_in and flags_in; set int_active; go to PUSH_PC.
- stall=1 in every state except IDLE.
- PUSH_PC: write latched PC at sp_in. On grant: sp_we, sp_wdata=sp_in-1 (mod 256).
  - Next state: PUSH_FL if interrupt, else DONE with target=call_target.
- PUSH_FL: write {4'b0,flags} at sp_in. On grant: sp_we, SP-1; next RD_VEC.
- RD_VEC: read INT_VEC_ADDR; WAIT_RD captures target=mem_rdata; next DONE.
- POP_FL: read sp_in+1. On grant: sp_we, sp_wdata=sp_in+1.
  - Next cycle: flags_we=1, flags_wdata=mem_rdata[3:0]; next POP_PC.
- POP_PC: read sp_in+1. On grant: sp_we, SP+1. Next cycle: target=mem_rdata; next DONE.
- DONE: one cycle with pc_load=1, pc_load_value=target, flush=1, stall=1; then IDLE.
  - If the sequence was RTI, int_active clears in DONE.
- SP arithmetic wraps mod 256 (0x00-1=0xFF, 0xFF+1=0x00). No overflow detection.
- intr arriving while not IDLE is ignored until IDLE; being level-sensitive, it is re-evaluated there.
- RET while int_active behaves as a normal RET; int_active is unchanged.
- Latency with grant held high:
  - CALL: 3 cycles (PUSH_PC, DONE, back in IDLE).
  - RET: 4 cycles.
  - RTI: 6 cycles.
  - Interrupt entry: 6 cycles.

Decomposition:
- Shared package: FSM state encoding, opcode constants (CALL=B/ra01, RET/RTI encodings), flag bit indices (Z=0, N=1, C=2, V=3), INT_VEC_ADDR default.
- One natural sub-module: stack_addr_gen (combinational sp±1 and push/pop address select).

Test Plan:
- CALL, sp_in=FF, call_target=40, ret_addr_in=13, grant=1 -> write M[FF]=13; sp_wdata=FE; pc_load=1, value=40, flush=1 on the 2nd cycle.
- RET, sp_in=FE, M[FF]=13 -> read addr FF; sp_wdata=FF; pc_load value 13; stall high for 3 cycles.
- intr=1 idle, int_pc_in=22, flags=4'b1010, sp=FF, M[01]=80 -> M[FF]=22; M[FE]=0A; SP=FD; pc_load 80; int_active=1; second intr while int_active is ignored.
- RTI, sp=FD -> flags_we with 4'b1010; then pc_load 22; SP=FF; int_active=0 in DONE.
- mem_grant held low 3 cycles during PUSH_PC -> mem_req/addr/wdata stable; no sp_we until grant.
- rst asserted in POP_PC -> next cycle IDLE with all outputs 0; ret and intr in the same cycle -> RET serviced first, then interrupt entry.

Source files
------------

// File: rtl/flow_ctrl_sequencer_pkg.sv
// Shared types and constants for the stack-transfer sequencer (CALL/RET/RTI/interrupt entry).
package flow_ctrl_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH_PC,
        ST_PUSH_FL,
        ST_RD_VEC,
        ST_WAIT_RD,
        ST_POP_FL,
        ST_POP_PC,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        SEQ_CALL,
        SEQ_RET,
        SEQ_RTI,
        SEQ_INT
    } seq_t;

    // Branch-class opcode and the function field selecting the stack transfers
    localparam logic [3:0] OPC_BRANCH = 4'hB;
    localparam logic [1:0] BR_CALL    = 2'b01;
    localparam logic [1:0] BR_RET     = 2'b10;
    localparam logic [1:0] BR_RTI     = 2'b11;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    localparam logic [7:0] INT_VEC_ADDR_DEF = 8'h01;
    localparam logic [7:0] SP_RESET_DEF     = 8'hFF;

endpackage

// File: rtl/flow_ctrl_sequencer_stack_addr_gen.sv
// Stack pointer neighbours and push/pop address select; all arithmetic wraps mod 256.
module flow_ctrl_sequencer_stack_addr_gen (
    input  logic [7:0] sp,
    input  logic       pop_sel,
    output logic [7:0] sp_inc,
    output logic [7:0] sp_dec,
    output logic [7:0] stack_addr
);

    assign sp_inc     = sp + 8'd1;
    assign sp_dec     = sp - 8'd1;
    assign stack_addr = pop_sel ? sp_inc : sp;

endmodule

// File: rtl/flow_ctrl_sequencer.sv
// Multi-cycle sequencer for CALL, RET, RTI and interrupt entry through the shared data-memory port.
//
// state    | meaning
// IDLE     | no transfer; pick rti > ret > call > intr
// PUSH_PC  | write latched PC at SP, SP-1 on grant
// PUSH_FL  | write latched flags at SP, SP-1 on grant (interrupt only)
// RD_VEC   | read ISR address from the vector location
// WAIT_RD  | capture read data: flags restore or PC target
// POP_FL   | read SP+1 for flags, SP+1 on grant (RTI only)
// POP_PC   | read SP+1 for return PC, SP+1 on grant
// DONE     | load PC, flush younger stages
module flow_ctrl_sequencer
    import flow_ctrl_sequencer_pkg::*;
#(
    parameter logic [7:0] INT_VEC_ADDR = INT_VEC_ADDR_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ex_mem_is_call,
    input  logic       ex_mem_is_ret,
    input  logic       ex_mem_is_rti,
    input  logic [7:0] call_target,
    input  logic [7:0] ret_addr_in,
    input  logic [7:0] int_pc_in,
    input  logic       intr,
    input  logic [3:0] flags_in,
    input  logic [7:0] sp_in,
    input  logic       mem_grant,
    input  logic [7:0] mem_rdata,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       sp_we,
    output logic [7:0] sp_wdata,
    output logic       flags_we,
    output logic [3:0] flags_wdata,
    output logic       pc_load,
    output logic [7:0] pc_load_value,
    output logic       stall,
    output logic       flush,
    output logic       int_active
);

    state_t     state_q, state_d;
    seq_t       seq_q, seq_d;
    logic [7:0] pc_lat_q, pc_lat_d;
    logic [3:0] fl_lat_q, fl_lat_d;
    logic [7:0] target_q, target_d;
    logic       rd_flags_q, rd_flags_d;
    logic       int_active_q, int_active_d;

    logic       pop_sel;
    logic [7:0] sp_inc, sp_dec, stack_addr;

    assign pop_sel = (state_q == ST_POP_FL) || (state_q == ST_POP_PC);

    flow_ctrl_sequencer_stack_addr_gen u_stack_addr_gen (
        .sp         (sp_in),
        .pop_sel    (pop_sel),
        .sp_inc     (sp_inc),
        .sp_dec     (sp_dec),
        .stack_addr (stack_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            seq_q        <= SEQ_CALL;
            pc_lat_q     <= '0;
            fl_lat_q     <= '0;
            target_q     <= '0;
            rd_flags_q   <= 1'b0;
            int_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            pc_lat_q     <= pc_lat_d;
            fl_lat_q     <= fl_lat_d;
            target_q     <= target_d;
            rd_flags_q   <= rd_flags_d;
            int_active_q <= int_active_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        seq_d         = seq_q;
        pc_lat_d      = pc_lat_q;
        fl_lat_d      = fl_lat_q;
        target_d      = target_q;
        rd_flags_d    = rd_flags_q;
        int_active_d  = int_active_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        sp_we         = 1'b0;
        sp_wdata      = '0;
        flags_we      = 1'b0;
        flags_wdata   = '0;
        pc_load       = 1'b0;
        pc_load_value = '0;
        flush         = 1'b0;
        stall         = (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                if (ex_mem_is_rti) begin
                    seq_d   = SEQ_RTI;
                    state_d = ST_POP_FL;
                end else if (ex_mem_is_ret) begin
                    seq_d   = SEQ_RET;
                    state_d = ST_POP_PC;
                end else if (ex_mem_is_call) begin
                    seq_d    = SEQ_CALL;
                    pc_lat_d = ret_addr_in;
                    target_d = call_target;
                    state_d  = ST_PUSH_PC;
                end else if (intr && !int_active_q) begin
                    seq_d        = SEQ_INT;
                    pc_lat_d     = int_pc_in;
                    fl_lat_d     = flags_in;
                    int_active_d = 1'b1;
                    state_d      = ST_PUSH_PC;
                end
            end
            ST_PUSH_PC: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = stack_addr;
                mem_wdata = pc_lat_q;
                if (mem_grant) begin
                    sp_we    = 1'b1;
                    sp_wdata = sp_dec;
                    state_d  = (seq_q == SEQ_INT) ? ST_PUSH_FL : ST_DONE;
                end
            end
            ST_PUSH_FL: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = stack_addr;
                mem_wdata = {4'b0000, fl_lat_q};
                if (mem_grant) begin
                    sp_we    = 1'b1;
                    sp_wdata = sp_dec;
                    state_d  = ST_RD_VEC;
                end
            end
            ST_RD_VEC: begin
                mem_req  = 1'b1;
                mem_addr = INT_VEC_ADDR;
                if (mem_grant) begin
                    rd_flags_d = 1'b0;
                    state_d    = ST_WAIT_RD;
                end
            end
            ST_POP_FL, ST_POP_PC: begin
                mem_req  = 1'b1;
                mem_addr = stack_addr;
                if (mem_grant) begin
                    sp_we      = 1'b1;
                    sp_wdata   = sp_inc;
                    rd_flags_d = (state_q == ST_POP_FL);
                    state_d    = ST_WAIT_RD;
                end
            end
            ST_WAIT_RD: begin
                if (rd_flags_q) begin
                    flags_we            = 1'b1;
                    flags_wdata[FLAG_Z] = mem_rdata[FLAG_Z];
                    flags_wdata[FLAG_N] = mem_rdata[FLAG_N];
                    flags_wdata[FLAG_C] = mem_rdata[FLAG_C];
                    flags_wdata[FLAG_V] = mem_rdata[FLAG_V];
                    state_d             = ST_POP_PC;
                end else begin
                    target_d = mem_rdata;
                    // Dropping int_active on entry to DONE lets it read low during the PC load
                    if (seq_q == SEQ_RTI) int_active_d = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                pc_load       = 1'b1;
                pc_load_value = target_q;
                flush         = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign int_active = int_active_q;

endmodule

// File: tb/tb_flow_ctrl_sequencer.sv
// Directed bench: models data memory, grant and the SP register around the sequencer.
module tb_flow_ctrl_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       ex_mem_is_call, ex_mem_is_ret, ex_mem_is_rti;
    logic [7:0] call_target, ret_addr_in, int_pc_in;
    logic       intr;
    logic [3:0] flags_in;
    logic       mem_grant;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_req, mem_we, sp_we, flags_we, pc_load, stall, flush, int_active;
    logic [7:0] mem_addr, mem_wdata, sp_wdata, pc_load_value;
    logic [3:0] flags_wdata;

    logic [7:0] sp_m = 8'hFF;
    logic [7:0] mem [256];
    logic       pre_we;
    logic [7:0] pre_addr, pre_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    flow_ctrl_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .ex_mem_is_call (ex_mem_is_call),
        .ex_mem_is_ret  (ex_mem_is_ret),
        .ex_mem_is_rti  (ex_mem_is_rti),
        .call_target    (call_target),
        .ret_addr_in    (ret_addr_in),
        .int_pc_in      (int_pc_in),
        .intr           (intr),
        .flags_in       (flags_in),
        .sp_in          (sp_m),
        .mem_grant      (mem_grant),
        .mem_rdata      (mem_rdata),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .sp_we          (sp_we),
        .sp_wdata       (sp_wdata),
        .flags_we       (flags_we),
        .flags_wdata    (flags_wdata),
        .pc_load        (pc_load),
        .pc_load_value  (pc_load_value),
        .stall          (stall),
        .flush          (flush),
        .int_active     (int_active)
    );

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_req && mem_grant && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_req && mem_grant && !mem_we) mem_rdata <= mem[mem_addr];
        if (sp_we) sp_m <= sp_wdata;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".stall"}, {7'd0, stall}, 8'd0);
        chk({tag, ".mem_req"}, {7'd0, mem_req}, 8'd0);
        chk({tag, ".pc_load"}, {7'd0, pc_load}, 8'd0);
        chk({tag, ".flush"}, {7'd0, flush}, 8'd0);
        chk({tag, ".sp_we"}, {7'd0, sp_we}, 8'd0);
        chk({tag, ".flags_we"}, {7'd0, flags_we}, 8'd0);
    endtask

    initial begin
        rst = 1'b1;
        ex_mem_is_call = 1'b0; ex_mem_is_ret = 1'b0; ex_mem_is_rti = 1'b0;
        call_target = 8'h00; ret_addr_in = 8'h00; int_pc_in = 8'h00;
        intr = 1'b0; flags_in = 4'h0; mem_grant = 1'b1;
        pre_we = 1'b1; pre_addr = 8'h01; pre_data = 8'h80;
        nxt();
        pre_addr = 8'h00; pre_data = 8'h55;
        nxt();
        pre_we = 1'b0;
        nxt();
        rst = 1'b0;
        nxt();
        chk_idle("reset");
        chk("reset.int_active", {7'd0, int_active}, 8'd0);

        // CALL from SP=FF
        ex_mem_is_call = 1'b1; call_target = 8'h40; ret_addr_in = 8'h13;
        nxt();
        ex_mem_is_call = 1'b0;
        chk("call.req", {7'd0, mem_req}, 8'd1);
        chk("call.we", {7'd0, mem_we}, 8'd1);
        chk("call.addr", mem_addr, 8'hFF);
        chk("call.wdata", mem_wdata, 8'h13);
        chk("call.sp_we", {7'd0, sp_we}, 8'd1);
        chk("call.sp_wdata", sp_wdata, 8'hFE);
        chk("call.stall", {7'd0, stall}, 8'd1);
        chk("call.early_pc_load", {7'd0, pc_load}, 8'd0);
        nxt();
        chk("call.pc_load", {7'd0, pc_load}, 8'd1);
        chk("call.pc_value", pc_load_value, 8'h40);
        chk("call.flush", {7'd0, flush}, 8'd1);
        nxt();
        chk("call.stall_end", {7'd0, stall}, 8'd0);
        chk("call.mem_ff", mem[8'hFF], 8'h13);
        chk("call.sp", sp_m, 8'hFE);

        // RET from SP=FE
        ex_mem_is_ret = 1'b1;
        nxt();
        ex_mem_is_ret = 1'b0;
        chk("ret.req", {7'd0, mem_req}, 8'd1);
        chk("ret.we", {7'd0, mem_we}, 8'd0);
        chk("ret.addr", mem_addr, 8'hFF);
        chk("ret.sp_wdata", sp_wdata, 8'hFF);
        chk("ret.stall1", {7'd0, stall}, 8'd1);
        nxt();
        chk("ret.capture_req", {7'd0, mem_req}, 8'd0);
        chk("ret.stall2", {7'd0, stall}, 8'd1);
        chk("ret.early_pc_load", {7'd0, pc_load}, 8'd0);
        nxt();
        chk("ret.pc_load", {7'd0, pc_load}, 8'd1);
        chk("ret.pc_value", pc_load_value, 8'h13);
        chk("ret.stall3", {7'd0, stall}, 8'd1);
        nxt();
        chk("ret.stall_end", {7'd0, stall}, 8'd0);
        chk("ret.sp", sp_m, 8'hFF);

        // Interrupt entry; inputs change after the latch cycle
        intr = 1'b1; int_pc_in = 8'h22; flags_in = 4'b1010;
        nxt();
        int_pc_in = 8'h00; flags_in = 4'h0;
        chk("int.active", {7'd0, int_active}, 8'd1);
        chk("int.pc_we", {7'd0, mem_we}, 8'd1);
        chk("int.pc_addr", mem_addr, 8'hFF);
        chk("int.pc_wdata", mem_wdata, 8'h22);
        chk("int.pc_sp", sp_wdata, 8'hFE);
        nxt();
        chk("int.fl_we", {7'd0, mem_we}, 8'd1);
        chk("int.fl_addr", mem_addr, 8'hFE);
        chk("int.fl_wdata", mem_wdata, 8'h0A);
        chk("int.fl_sp", sp_wdata, 8'hFD);
        nxt();
        chk("int.vec_req", {7'd0, mem_req}, 8'd1);
        chk("int.vec_we", {7'd0, mem_we}, 8'd0);
        chk("int.vec_addr", mem_addr, 8'h01);
        chk("int.vec_sp_we", {7'd0, sp_we}, 8'd0);
        nxt();
        chk("int.capture_req", {7'd0, mem_req}, 8'd0);
        nxt();
        chk("int.pc_load", {7'd0, pc_load}, 8'd1);
        chk("int.pc_value", pc_load_value, 8'h80);
        chk("int.flush", {7'd0, flush}, 8'd1);
        nxt();
        chk_idle("int.idle");
        chk("int.active_held", {7'd0, int_active}, 8'd1);
        nxt();
        chk_idle("int.nested_ignored");
        intr = 1'b0;
        chk("int.mem_fe", mem[8'hFE], 8'h0A);
        chk("int.sp", sp_m, 8'hFD);

        // RTI from SP=FD
        ex_mem_is_rti = 1'b1;
        nxt();
        ex_mem_is_rti = 1'b0;
        chk("rti.fl_addr", mem_addr, 8'hFE);
        chk("rti.fl_we", {7'd0, mem_we}, 8'd0);
        chk("rti.fl_sp", sp_wdata, 8'hFE);
        nxt();
        chk("rti.flags_we", {7'd0, flags_we}, 8'd1);
        chk("rti.flags_wdata", {4'd0, flags_wdata}, 8'h0A);
        chk("rti.capture_req", {7'd0, mem_req}, 8'd0);
        nxt();
        chk("rti.pc_addr", mem_addr, 8'hFF);
        chk("rti.pc_sp", sp_wdata, 8'hFF);
        chk("rti.flags_we_off", {7'd0, flags_we}, 8'd0);
        nxt();
        chk("rti.pc_capture_req", {7'd0, mem_req}, 8'd0);
        chk("rti.active_before_done", {7'd0, int_active}, 8'd1);
        nxt();
        chk("rti.pc_load", {7'd0, pc_load}, 8'd1);
        chk("rti.pc_value", pc_load_value, 8'h22);
        chk("rti.active_cleared", {7'd0, int_active}, 8'd0);
        nxt();
        chk_idle("rti.idle");
        chk("rti.sp", sp_m, 8'hFF);

        // CALL with grant withheld for three cycles
        mem_grant = 1'b0;
        ex_mem_is_call = 1'b1; call_target = 8'h77; ret_addr_in = 8'h31;
        nxt();
        ex_mem_is_call = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wait.req", {7'd0, mem_req}, 8'd1);
            chk("wait.addr", mem_addr, 8'hFF);
            chk("wait.wdata", mem_wdata, 8'h31);
            chk("wait.sp_we", {7'd0, sp_we}, 8'd0);
            chk("wait.pc_load", {7'd0, pc_load}, 8'd0);
            nxt();
        end
        mem_grant = 1'b1;
        #1;
        chk("wait.grant_sp_we", {7'd0, sp_we}, 8'd1);
        chk("wait.grant_sp", sp_wdata, 8'hFE);
        nxt();
        chk("wait.pc_value", pc_load_value, 8'h77);
        nxt();
        chk("wait.sp", sp_m, 8'hFE);
        ex_mem_is_ret = 1'b1;
        nxt();
        ex_mem_is_ret = 1'b0;
        nxt();
        nxt();
        chk("wait.ret_value", pc_load_value, 8'h31);
        nxt();
        chk("wait.ret_sp", sp_m, 8'hFF);

        // RET at SP=FF wraps to address 00; reset while stuck in POP_PC
        mem_grant = 1'b0;
        ex_mem_is_ret = 1'b1;
        nxt();
        ex_mem_is_ret = 1'b0;
        chk("rst.pop_req", {7'd0, mem_req}, 8'd1);
        chk("rst.pop_addr_wrap", mem_addr, 8'h00);
        rst = 1'b1;
        nxt();
        chk_idle("rst.mid");
        chk("rst.int_active", {7'd0, int_active}, 8'd0);
        rst = 1'b0;
        mem_grant = 1'b1;

        // RET and intr together: RET first, then interrupt entry
        ex_mem_is_ret = 1'b1; intr = 1'b1; int_pc_in = 8'h66; flags_in = 4'b0101;
        nxt();
        ex_mem_is_ret = 1'b0;
        chk("prio.we", {7'd0, mem_we}, 8'd0);
        chk("prio.addr", mem_addr, 8'h00);
        chk("prio.sp_wrap", sp_wdata, 8'h00);
        chk("prio.int_active", {7'd0, int_active}, 8'd0);
        nxt();
        nxt();
        chk("prio.ret_value", pc_load_value, 8'h55);
        nxt();
        chk("prio.idle_stall", {7'd0, stall}, 8'd0);
        nxt();
        chk("prio.int_we", {7'd0, mem_we}, 8'd1);
        chk("prio.int_addr", mem_addr, 8'h00);
        chk("prio.int_wdata", mem_wdata, 8'h66);
        chk("prio.int_sp_wrap", sp_wdata, 8'hFF);
        chk("prio.int_active", {7'd0, int_active}, 8'd1);
        intr = 1'b0;
        nxt();
        chk("prio.fl_addr", mem_addr, 8'hFF);
        chk("prio.fl_wdata", mem_wdata, 8'h05);
        nxt();
        nxt();
        nxt();
        chk("prio.int_pc_value", pc_load_value, 8'h80);
        chk("prio.int_pc_load", {7'd0, pc_load}, 8'd1);
        nxt();
        chk("prio.end_stall", {7'd0, stall}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
